// File: rtl/micron_pkg.sv
// Shared receiver-housekeeping definitions: attenuation code width, default
// attenuation ceiling, automatic attenuation state encoding and clamp helper.
package micron_pkg;

    localparam int unsigned ATT_W       = 8;
    localparam int unsigned MAX_ATT_DEF = 62;
    localparam int unsigned OF_CNT_W    = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        MONITOR = 1'b1
    } att_state_t;

    // Clamp a carry-extended attenuation sum to the ceiling.
    function automatic logic [ATT_W-1:0] att_clamp(input logic [ATT_W:0]   sum,
                                                   input logic [ATT_W-1:0] max_att);
        return (sum > {1'b0, max_att}) ? max_att : sum[ATT_W-1:0];
    endfunction

endpackage

// File: rtl/of_edge_sync.sv
// Brings an asynchronous overflow flag into the local clock domain and emits a
// one-cycle pulse per rising edge; a flag held high yields a single pulse.
module of_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    // [0] first sync stage, [1] second sync stage, [2] previous synced value
    logic [2:0] sync_q;

    // Synchronizer chain and registered rising-edge detect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], async_in};
            rise   <= sync_q[1] & ~sync_q[2];
        end
    end

endmodule

// File: rtl/att_auto_ctrl.sv
// Overload-driven automatic attenuation on top of the host attenuation code.
// Build option: define ATT_AUTO_RELEASE_EN to compile in the hold counter and
// the release step that walks extra attenuation back down after clean windows.
module att_auto_ctrl
    import micron_pkg::*;
#(
    parameter int unsigned WIN_LEN   = 2000,
    parameter int unsigned OF_THRESH = 4,
    parameter int unsigned STEP      = 2,
    parameter int unsigned MAX_ATT   = MAX_ATT_DEF,
    parameter int unsigned HOLD_WIN  = 500
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                auto_on,
    input  logic                adc_of,
    input  logic [ATT_W-1:0]    att_user,
    output logic [ATT_W-1:0]    att_out,
    output logic                att_load,
    output logic [OF_CNT_W-1:0] of_count
);

    localparam int unsigned WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int unsigned EV_W  = $clog2(OF_THRESH + 1);

    att_state_t       state;
    logic [WIN_W-1:0] win_cnt;
    logic [EV_W-1:0]  ev_cnt;
    logic [ATT_W-1:0] extra;
    logic             of_rise;

    logic [ATT_W:0]   sum_c;
    logic [ATT_W-1:0] combined_c;
    logic [ATT_W-1:0] headroom_c;
    logic [ATT_W-1:0] extra_up_c;
    logic [EV_W-1:0]  ev_next_c;
    logic             overload_c;
    logic             win_end_c;
    logic             active_c;

    of_edge_sync u_of_edge_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (adc_of),
        .rise     (of_rise)
    );

    // Combined code, window bookkeeping and step-up amount.
    always_comb begin
        sum_c      = {1'b0, att_user} + {1'b0, extra};
        combined_c = att_clamp(sum_c, ATT_W'(MAX_ATT));
        headroom_c = ATT_W'(MAX_ATT) - combined_c;
        extra_up_c = extra + ((headroom_c < ATT_W'(STEP)) ? headroom_c : ATT_W'(STEP));
        ev_next_c  = (of_rise && (ev_cnt < EV_W'(OF_THRESH))) ? ev_cnt + EV_W'(1) : ev_cnt;
        overload_c = (ev_next_c >= EV_W'(OF_THRESH));
        win_end_c  = (win_cnt == WIN_W'(WIN_LEN - 1));
        active_c   = enable & auto_on;
    end

`ifdef ATT_AUTO_RELEASE_EN
    localparam int unsigned HOLD_W = (HOLD_WIN > 0) ? $clog2(HOLD_WIN + 1) : 1;

    logic [HOLD_W-1:0] hold_cnt;
    logic [ATT_W-1:0]  extra_dn_c;
    logic              hold_done_c;

    // Release amount and hold-expiry test for a clean window.
    always_comb begin
        extra_dn_c  = (extra > ATT_W'(STEP)) ? extra - ATT_W'(STEP) : '0;
        hold_done_c = ((32'(hold_cnt) + 32'd1) >= HOLD_WIN);
    end
`else
    // Hold length only matters when the release logic is built in.
    logic unused_hold_win;
    assign unused_hold_win = |32'(HOLD_WIN);
`endif

    // Control FSM: window/event counting and extra-attenuation adjustment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            win_cnt  <= '0;
            ev_cnt   <= '0;
            extra    <= '0;
            of_count <= '0;
`ifdef ATT_AUTO_RELEASE_EN
            hold_cnt <= '0;
`endif
        end else if (!active_c) begin
            state    <= IDLE;
            win_cnt  <= '0;
            ev_cnt   <= '0;
            extra    <= '0;
`ifdef ATT_AUTO_RELEASE_EN
            hold_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state <= MONITOR;
                end
                MONITOR: begin
                    if (win_end_c) begin
                        win_cnt <= '0;
                        ev_cnt  <= '0;
                        if (overload_c) begin
                            if (of_count != {OF_CNT_W{1'b1}}) begin
                                of_count <= of_count + OF_CNT_W'(1);
                            end
                            if (combined_c < ATT_W'(MAX_ATT)) begin
                                extra <= extra_up_c;
                            end
`ifdef ATT_AUTO_RELEASE_EN
                            hold_cnt <= '0;
                        end else if (hold_done_c) begin
                            if (extra != '0) begin
                                extra    <= extra_dn_c;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= HOLD_W'(HOLD_WIN);
                            end
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
`endif
                        end
                    end else begin
                        win_cnt <= win_cnt + WIN_W'(1);
                        ev_cnt  <= ev_next_c;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output register: reload and strobe only when the combined code changes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            att_out  <= '0;
            att_load <= 1'b0;
        end else if (combined_c != att_out) begin
            att_out  <= combined_c;
            att_load <= 1'b1;
        end else begin
            att_load <= 1'b0;
        end
    end

endmodule

// File: tb/tb_att_auto_ctrl.sv
// Self-checking bench for att_auto_ctrl: directed scenarios plus randomized
// traffic, every cycle compared against a rule-level reference model.
module tb_att_auto_ctrl;

    localparam int unsigned WIN_LEN   = 100;
    localparam int unsigned OF_THRESH = 4;
    localparam int unsigned STEP      = 2;
    localparam int unsigned MAX_ATT   = 62;
    localparam int unsigned HOLD_WIN  = 3;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        auto_on;
    logic        adc_of;
    logic [7:0]  att_user;
    logic [7:0]  att_out;
    logic        att_load;
    logic [15:0] of_count;

    int n_checks;
    int n_errors;
    int n_loads;

    // reference model state
    bit m_mon;
    int m_pos;
    int m_ev;
    int m_hold;
    int m_extra;
    int m_ofc;
    int m_out;
    int m_load;
    bit h[4];

    att_auto_ctrl #(
        .WIN_LEN   (WIN_LEN),
        .OF_THRESH (OF_THRESH),
        .STEP      (STEP),
        .MAX_ATT   (MAX_ATT),
        .HOLD_WIN  (HOLD_WIN)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .auto_on  (auto_on),
        .adc_of   (adc_of),
        .att_user (att_user),
        .att_out  (att_out),
        .att_load (att_load),
        .of_count (of_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mon = 0; m_pos = 0; m_ev = 0; m_hold = 0;
        m_extra = 0; m_ofc = 0; m_out = 0; m_load = 0;
        for (int i = 0; i < 4; i++) h[i] = 1'b0;
    endtask

    // One clock edge of behaviour, using the inputs present at that edge.
    task automatic model_step();
        int user;
        int comb;
        bit evt;
        user = int'(att_user);
        comb = user + m_extra;
        if (comb > int'(MAX_ATT)) comb = int'(MAX_ATT);
        // overflow edge reaches the counter three edges after it is sampled
        evt = h[2] && !h[3];
        if (comb != m_out) begin
            m_out = comb; m_load = 1;
        end else begin
            m_load = 0;
        end
        if (!(enable && auto_on)) begin
            m_mon = 0; m_extra = 0; m_pos = 0; m_ev = 0; m_hold = 0;
        end else if (!m_mon) begin
            m_mon = 1;
        end else begin
            if (evt) m_ev++;
            if (m_pos == int'(WIN_LEN) - 1) begin
                if (m_ev >= int'(OF_THRESH)) begin
                    if (m_ofc < 65535) m_ofc++;
                    m_hold = 0;
                    if (comb < int'(MAX_ATT)) begin
                        m_extra = m_extra + int'(STEP);
                        if (user + m_extra > int'(MAX_ATT)) m_extra = int'(MAX_ATT) - user;
                    end
                end else begin
`ifdef ATT_AUTO_RELEASE_EN
                    m_hold++;
                    if (m_hold >= int'(HOLD_WIN) && m_extra > 0) begin
                        m_extra = m_extra - int'(STEP);
                        if (m_extra < 0) m_extra = 0;
                        m_hold = 0;
                    end
`endif
                end
                m_pos = 0;
                m_ev  = 0;
            end else begin
                m_pos++;
            end
        end
        h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = adc_of;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check("att_out", int'(att_out), m_out);
        check("att_load", int'(att_load), m_load);
        check("of_count", int'(of_count), m_ofc);
        if (att_load) n_loads++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_att_out", int'(att_out), 0);
        check("rst_att_load", int'(att_load), 0);
        check("rst_of_count", int'(of_count), 0);
        model_reset();
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    task automatic pulses(input int n, input int w);
        for (int i = 0; i < n; i++) begin
            adc_of = 1'b1;
            run(w);
            adc_of = 1'b0;
            run(2);
        end
    endtask

    // Move to the start of a window so a pulse burst stays inside it.
    task automatic align();
        for (int k = 0; k < int'(WIN_LEN) + 4 && m_pos != 1; k++) tick();
    endtask

    task automatic overload_window();
        align();
        pulses(5, 2);
        run(int'(WIN_LEN) - 10);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; n_loads = 0;
        reset = 1'b1; enable = 1'b0; auto_on = 1'b0; adc_of = 1'b0; att_user = 8'd0;
        model_reset();
        do_reset();

        // host code passes straight through while automatic mode is off
        enable = 1'b1; att_user = 8'd10; n_loads = 0;
        tick();
        check("s1_out", int'(att_out), 10);
        run(3);
        check("s1_loads", n_loads, 1);
        check("s1_ofc", int'(of_count), 0);

        // five overloads in one window add one step
        auto_on = 1'b1;
        tick();
        n_loads = 0;
        overload_window();
        check("s2_out", int'(att_out), 12);
        check("s2_loads", n_loads, 1);
        check("s2_ofc", int'(of_count), 1);

        // below threshold, and one long held overflow, change nothing
        align(); pulses(3, 2); run(110);
        check("s3_out_three", int'(att_out), 12);
        align(); adc_of = 1'b1; run(50); adc_of = 1'b0; run(60);
        check("s3_out_held", int'(att_out), 12);
        check("s3_ofc", int'(of_count), 1);

        overload_window();
        check("s4_out", int'(att_out), 14);
        check("s4_ofc", int'(of_count), 2);

        // drop enable mid-window: back to host code with one strobe
        run(30);
        n_loads = 0;
        enable = 1'b0;
        run(2);
        check("s5_out", int'(att_out), 10);
        check("s5_loads", n_loads, 1);
        enable = 1'b1;
        run(5);

        // clamp at the ceiling, then a saturated overload window
        att_user = 8'd61;
        run(2);
        check("s6_out_user", int'(att_out), 61);
        overload_window();
        check("s6_out_clamp", int'(att_out), 62);
        check("s6_ofc", int'(of_count), 3);
        n_loads = 0;
        overload_window();
        check("s6_loads_sat", n_loads, 0);
        check("s6_ofc2", int'(of_count), 4);

        // build up to 14, then reset mid-window
        enable = 1'b0; att_user = 8'd10; tick();
        enable = 1'b1; tick();
        overload_window();
        overload_window();
        check("s7_out", int'(att_out), 14);
        run(40);
        do_reset();
        tick();
        check("s8_out_after_rst", int'(att_out), 10);

        // release behaviour over clean windows
        overload_window();
        overload_window();
        check("s9_out_base", int'(att_out), 14);
        run(3 * int'(WIN_LEN) + 5);
`ifdef ATT_AUTO_RELEASE_EN
        check("s9_out_rel1", int'(att_out), 12);
`else
        check("s9_out_rel1", int'(att_out), 14);
`endif
        run(3 * int'(WIN_LEN));
`ifdef ATT_AUTO_RELEASE_EN
        check("s9_out_rel2", int'(att_out), 10);
`else
        run(4 * int'(WIN_LEN));
        check("s9_out_hold", int'(att_out), 14);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            if ($urandom_range(0, 399) == 0) auto_on = ~auto_on;
            if ($urandom_range(0, 149) == 0) begin
                if ($urandom_range(0, 3) == 0) att_user = 8'($urandom_range(0, 255));
                else att_user = 8'($urandom_range(0, 70));
            end
            if ($urandom_range(0, 11) == 0) adc_of = ~adc_of;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/att_auto_ctrl.md
# att_auto_ctrl

Automatic overload-driven attenuation stage between the host attenuation setting from `usb_control` and the `attenuator` serial writer. It monitors the ADC overflow flag and, when overloads recur, adds extra attenuation on top of the host value. It presents the combined code to `attenuator` with a single-cycle load strobe. Runs in the `clock_02` housekeeping domain.

## Interface
- WIN_LEN, 2000: observation window length in clock cycles.
- OF_THRESH, 4: number of overload events in one window that marks it as an overload window.
- STEP, 2: attenuation code units added or removed per adjustment.
- MAX_ATT, 62: maximum combined attenuation code.
- HOLD_WIN, 500: consecutive clean windows required before one release step.

Ports:
- clock  in  1  housekeeping clock (`clock_02`).
- reset  in  1  asynchronous, active-high.
- enable  in  1  receiver or bandscope active (`rx_on | bs_on`).
- auto_on  in  1  host enable for automatic attenuation.
- adc_of  in  1  raw ADC overflow flag, asynchronous to `clock`.
- att_user  in  8  host attenuation code.
- att_out  out  8  combined code sent to `attenuator`.
- att_load  out  1  one-cycle strobe, asserted in the cycle `att_out` takes a new value.
- of_count  out  16  saturating count of overload windows (diagnostic).

One clock; reset is asynchronous and active-high.

## Operation
- `adc_of` passes through a 2-FF synchronizer and then a rising-edge detector. One rising edge is one event.
  - `adc_of` held high continuously counts as a single event.
- Event counter saturates at OF_THRESH and clears at every window end.
- Window counter runs 0..WIN_LEN-1 and wraps. An event in the terminal cycle counts toward the closing window.
- `extra` register, 8 bits. Combined value = min(att_user + extra, MAX_ATT), computed as a 9-bit sum and then clamped.
- States:
  - IDLE: `extra` = 0; window, event and hold counters held at 0. Go to MONITOR when `enable && auto_on`.
  - MONITOR: action taken at each window end:
    - Overload window: increment `of_count` (saturate at 0xFFFF) and clear the hold counter. If the combined value is below MAX_ATT, set `extra` += STEP, clamped so the combined value is at most MAX_ATT.
    - Clean window: increment the hold counter. When it reaches HOLD_WIN and `extra` > 0, set `extra` -= STEP (floor 0) and clear the hold counter (release feature only).
  - Dropping `enable` or `auto_on` from any state returns to IDLE on the next edge. `of_count` is preserved.
- `att_out` update: every cycle, compare the combined value with `att_out`. If they differ, load it and assert `att_load` for exactly that cycle; otherwise `att_load` = 0.
- A change on `att_user` takes effect through the same path, with the current `extra` retained and the result clamped.
- Reset values: `att_out` = 0, `att_load` = 0, `of_count` = 0, `extra` = 0, state IDLE, all counters 0.

## Timing
- `adc_of` rising edge to counted event: 3 clock cycles (2 synchronizer stages plus the edge register).
- Window-end decision to `extra` update: 1 cycle. `extra` to `att_out`/`att_load`: 1 further cycle.
- `att_user` change to `att_out`: 1 cycle.
- Exit to IDLE: `extra` = 0 on the next edge; `att_out` equals the clamped `att_user` one cycle later.
- `att_load` is never asserted on two consecutive cycles unless the inputs change on consecutive cycles.
- Reset mid-window: all outputs and counters are 0 immediately. The first `att_load` after reset follows the first nonzero combined value.

## Configuration
- `ATT_AUTO_RELEASE_EN` defined: the hold counter and the release-step logic are compiled in.
- Not defined: `extra` only increases while in MONITOR and is cleared only on the transition to IDLE. The hold counter is absent, and the HOLD_WIN parameter is accepted but unused.

## Structure
- The shared package `micron_pkg` holds ATT_W = 8, the default MAX_ATT, and the state enum (IDLE, MONITOR).
- One sub-module, `of_edge_sync`: the 2-FF synchronizer plus rising-edge detector, reused by `clip_led`.
- The top block contains the FSM, counters, clamp adder and output register.

## Test plan
All scenarios use WIN_LEN = 100, OF_THRESH = 4, STEP = 2, MAX_ATT = 62, HOLD_WIN = 3.
- Reset, then enable = 1, auto_on = 0, att_user = 10 -> att_out = 10 after 1 cycle, one `att_load` pulse, `of_count` = 0.
- auto_on = 1, 5 `adc_of` pulses in one window -> at window end +2 cycles, att_out = 12, single `att_load`, `of_count` = 1. Three pulses only, or one pulse held 50 cycles -> no change.
- att_user = 61, overload window -> att_out = 62. A second overload window -> no `att_load`, `of_count` increments.
- With `ATT_AUTO_RELEASE_EN`: `extra` = 4, then 3 clean windows -> att_out drops by 2; 3 more -> att_out = att_user. Without the macro -> att_out unchanged after 10 clean windows.
- enable dropped mid-window with `extra` = 4 -> att_out = att_user within 2 cycles, one `att_load`; re-enabling starts a fresh window.
- Reset asserted mid-window with att_out = 14 -> att_out = 0, att_load = 0 and of_count = 0 asynchronously.
